// File: rtl/n64adv_vout_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : n64adv_vout_stage_if
//  Brief    : Pixel-in / video-out bus of the N64Adv output stage.
//  Revision : 1.0  initial release
// ============================================================================
interface n64adv_vout_stage_if #(
    parameter int color_width = 8
);
    logic                         vdata_valid_i;
    logic [4+3*color_width-1:0]   vdata_i;
    logic [3*color_width-1:0]     VD_o;
    logic [1:0]                   nCSYNC;
    logic                         nVSYNC_or_F2;
    logic                         nHSYNC_or_F1;

    modport master (
        output vdata_valid_i, vdata_i,
        input  VD_o, nCSYNC, nVSYNC_or_F2, nHSYNC_or_F1
    );

    modport slave (
        input  vdata_valid_i, vdata_i,
        output VD_o, nCSYNC, nVSYNC_or_F2, nHSYNC_or_F1
    );
endinterface
`default_nettype wire

// File: rtl/n64adv_vout_stage.sv
`default_nettype none
// ============================================================================
//  Module   : n64adv_vout_stage
//  Brief    : Output stage: R/B swap, blur line, blanking, sync generation and
//             vsync-aligned video filter switching.
//  Revision : 1.0  initial release
// ============================================================================
module n64adv_vout_stage #(
    parameter int color_width = 8,
    parameter int blur_depth  = 2,
    parameter int to_width    = 20
) (
    input  wire        VCLK_Tx,
    input  wire        nVRST_Tx,
    n64adv_vout_stage_if.slave vio,
    input  wire        cfg_exchange_rb,
    input  wire  [1:0] cfg_blur_mode,
    input  wire  [1:0] cfg_blur_sel,
    input  wire        cfg_ypbpr_en,
    input  wire        cfg_rgsb_en,
    input  wire        cfg_blank_en,
    input  wire        cfg_use_vga_hvsync,
    input  wire        cfg_hsync_inv,
    input  wire        cfg_vsync_inv,
    input  wire  [2:0] cfg_filter,
    input  wire  [1:0] cfg_linemult,
    output logic [1:0] filter_o,
    output logic       filter_pending_o
);
    localparam int c_cw = color_width;
    localparam int c_ww = 3 * color_width;
    localparam logic [c_cw-1:0] c_half = {1'b1, {(c_cw-1){1'b0}}};

    typedef enum logic [0:0] {
        F_IDLE = 1'b0,
        F_PEND = 1'b1
    } fstate_t;

    logic [3:0]      w_sync;
    logic [c_ww-1:0] w_swap;
    logic [c_ww-1:0] w_tap;
    logic [c_ww-1:0] w_avg;
    logic [c_ww-1:0] w_col;
    logic [1:0]      w_target;
    logic            w_vs_fall;

    logic [c_ww-1:0] r_taps [blur_depth];
    logic [c_ww-1:0] r_vd;
    logic [1:0]      r_ncs;
    logic            r_vs_prev;
    logic            r_nv;
    logic            r_nh;

    fstate_t            r_state, w_state_nxt;
    logic [1:0]         r_filter, w_filter_nxt;
    logic [to_width-1:0] r_cnt, w_cnt_nxt;

    assign w_sync = vio.vdata_i[4+c_ww-1:c_ww];
    assign w_swap = cfg_exchange_rb ?
                    {vio.vdata_i[c_cw-1:0], vio.vdata_i[2*c_cw-1:c_cw], vio.vdata_i[c_ww-1:2*c_cw]} :
                    vio.vdata_i[c_ww-1:0];

    // Highest tap not above the selector wins, which also clamps out-of-range selects.
    always_comb begin
        w_tap = r_taps[0];
        for (int i = 1; i < blur_depth; i++) begin
            if (int'(cfg_blur_sel) >= i) begin
                w_tap = r_taps[i];
            end
        end
    end

    generate
        for (genvar k = 0; k < 3; k++) begin : g_avg
            logic [c_cw:0] w_sum;
            assign w_sum = {1'b0, w_swap[k*c_cw +: c_cw]} + {1'b0, w_tap[k*c_cw +: c_cw]};
            assign w_avg[k*c_cw +: c_cw] = w_sum[c_cw:1];
        end
    endgenerate

    always_comb begin
        w_col = w_swap;
        case (cfg_blur_mode)
            2'b01:   w_col = w_tap;
            2'b10:   w_col = w_avg;
            default: w_col = w_swap;
        endcase
        if (cfg_blank_en && !w_sync[2]) begin
            w_col = '0;
            if (cfg_ypbpr_en) begin
                w_col[2*c_cw-1:0] = {c_half, c_half};
            end
        end
    end

    always_ff @(posedge VCLK_Tx or negedge nVRST_Tx) begin
        if (!nVRST_Tx) begin
            for (int i = 0; i < blur_depth; i++) begin
                r_taps[i] <= '0;
            end
        end else if (vio.vdata_valid_i) begin
            r_taps[0] <= w_swap;
            for (int i = 1; i < blur_depth; i++) begin
                r_taps[i] <= r_taps[i-1];
            end
        end
    end

    always_ff @(posedge VCLK_Tx or negedge nVRST_Tx) begin
        if (!nVRST_Tx) begin
            r_vd      <= '0;
            r_ncs     <= 2'b00;
            r_vs_prev <= 1'b1;
        end else if (vio.vdata_valid_i) begin
            r_vd      <= w_col;
            r_ncs     <= {w_sync[0], (cfg_rgsb_en | cfg_ypbpr_en) & w_sync[0]};
            r_vs_prev <= w_sync[3];
        end
    end

    assign w_target  = (cfg_filter == 3'b000) ? cfg_linemult : (cfg_filter[1:0] - 2'd1);
    assign w_vs_fall = vio.vdata_valid_i && r_vs_prev && !w_sync[3];

    // A pending filter change is applied at the next frame start, or after the timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_filter_nxt = r_filter;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            F_IDLE: begin
                if (w_target != r_filter) begin
                    w_state_nxt = F_PEND;
                    w_cnt_nxt   = '0;
                end
            end
            F_PEND: begin
                if (w_target == r_filter) begin
                    w_state_nxt = F_IDLE;
                end else if (w_vs_fall || (&r_cnt)) begin
                    w_filter_nxt = w_target;
                    w_state_nxt  = F_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + to_width'(1);
                end
            end
            default: w_state_nxt = F_IDLE;
        endcase
    end

    always_ff @(posedge VCLK_Tx or negedge nVRST_Tx) begin
        if (!nVRST_Tx) begin
            r_state  <= F_IDLE;
            r_filter <= 2'b00;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_filter <= w_filter_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_ff @(posedge VCLK_Tx or negedge nVRST_Tx) begin
        if (!nVRST_Tx) begin
            r_nv <= 1'b0;
            r_nh <= 1'b0;
        end else if (!cfg_use_vga_hvsync) begin
            {r_nv, r_nh} <= w_filter_nxt;
        end else if (vio.vdata_valid_i) begin
            r_nv <= w_sync[3] ^ cfg_vsync_inv;
            r_nh <= w_sync[1] ^ cfg_hsync_inv;
        end
    end

    assign vio.VD_o         = r_vd;
    assign vio.nCSYNC       = r_ncs;
    assign vio.nVSYNC_or_F2 = r_nv;
    assign vio.nHSYNC_or_F1 = r_nh;
    assign filter_o         = r_filter;
    assign filter_pending_o = (r_state == F_PEND);
endmodule
`default_nettype wire

// File: doc/n64adv_vout_stage.md
N64ADV_VOUT_STAGE -- requirements
Module: n64adv_vout_stage

Interface
REQ-001 Parameter color_width, default 8: bits per colour channel on input and output.
REQ-002 Parameter blur_depth, default 2: number of pixel-delay taps in the blur line, range 1..4.
REQ-003 Parameter to_width, default 20: width of the filter-change timeout counter.
REQ-004 Port VCLK_Tx, input, 1: the block's only clock; all logic is on its rising edge.
REQ-005 Port nVRST_Tx, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port vdata_valid_i, input, 1: pixel strobe.
REQ-007 Port vdata_i, input, 4+3*color_width: {Sync[3:0],R,G,B}; Sync = {nVSYNC,nBLANK,nHSYNC,nCSYNC}.
REQ-008 Port cfg_exchange_rb, input, 1: swap the R and B output channels.
REQ-009 Port cfg_blur_mode, input, 2: 00 off, 01 tap select, 10 average, 11 treated as off.
REQ-010 Port cfg_blur_sel, input, 2: blur tap index; values >= blur_depth clamp to blur_depth-1.
REQ-011 Port cfg_ypbpr_en / cfg_rgsb_en / cfg_blank_en / cfg_use_vga_hvsync, input, 1 each.
REQ-012 Port cfg_hsync_inv / cfg_vsync_inv, input, 1 each: output polarity inversion.
REQ-013 Port cfg_filter, input, 3: 000 auto, 001..100 fixed filter; cfg_linemult, input, 2.
REQ-014 Port VD_o, output, 3*color_width: registered colour out.
REQ-015 Port nCSYNC, output, 2: [1] always csync, [0] sync-on-green/Y.
REQ-016 Port nVSYNC_or_F2 / nHSYNC_or_F1, output, 1 each: VGA syncs or filter select.
REQ-017 Port filter_o, output, 2: applied filter; filter_pending_o, output, 1: a filter change is deferred.

Function
REQ-018 All registered outputs SHALL update only on cycles with vdata_valid_i=1, except the filter logic (REQ-027..031).
REQ-019 Latency from the vdata_valid_i sample to VD_o/nCSYNC SHALL be exactly 1 VCLK_Tx cycle.
REQ-020 Channel order after swap SHALL be {B,G,R} when cfg_exchange_rb=1, else {R,G,B}.
REQ-021 The blur line SHALL shift the swapped colour word on each valid pixel through blur_depth registers, tap0 = newest.
REQ-022 Tap-select mode SHALL output the clamped tap colour.
REQ-023 Average mode SHALL output per channel (cur + tap)>>1, computed at color_width+1 bits and truncated.
REQ-024 Blanking: if cfg_blank_en=1 and Sync[2]=0, colour SHALL be 0, except Pb/Pr which SHALL be 2^(color_width-1) when cfg_ypbpr_en=1; blanking overrides blur.
REQ-025 nCSYNC[1] SHALL equal Sync[0]; nCSYNC[0] SHALL equal Sync[0] if cfg_rgsb_en or cfg_ypbpr_en, else 0.
REQ-026 When cfg_use_vga_hvsync=1, nVSYNC_or_F2 SHALL be Sync[3]^cfg_vsync_inv and nHSYNC_or_F1 SHALL be Sync[1]^cfg_hsync_inv, both updated on valid.
REQ-027 Target filter SHALL be cfg_linemult when cfg_filter=000, else cfg_filter[1:0]-1 modulo 4 (100 gives 11).
REQ-028 Filter FSM states SHALL be F_IDLE and F_PEND; in F_IDLE, target != filter_o moves to F_PEND, clears the timeout counter, and sets filter_pending_o.
REQ-029 In F_PEND, filter_o SHALL load the current target on a valid pixel whose Sync[3] falls 1->0 versus the previous valid pixel, or when the timeout counter reaches all-ones; the FSM then returns to F_IDLE.
REQ-030 If the target returns to filter_o while in F_PEND, the FSM SHALL return to F_IDLE without a load; a target change during F_PEND SHALL NOT restart the counter.
REQ-031 When cfg_use_vga_hvsync=0, {nVSYNC_or_F2,nHSYNC_or_F1} SHALL equal filter_o every cycle, registered.

Reset
REQ-032 On nVRST_Tx=0: VD_o=0, nCSYNC=00, nVSYNC_or_F2=0, nHSYNC_or_F1=0, filter_o=00, filter_pending_o=0, FSM=F_IDLE, blur taps=0, timeout counter=0, previous-Sync[3] register=1.
REQ-033 Reset asserted mid-frame or mid-F_PEND SHALL abandon the pending change; after release, the first valid pixel produces normal output.

Verification
REQ-034 Valid pixel R=0x10,G=0x20,B=0x30 with exchange_rb=1, blur off -> VD_o={0x30,0x20,0x10} one cycle later.
REQ-035 blur_depth=2, average mode, sel=0, pixels 0x00 then 0xFF on all channels -> second output 0x7F per channel.
REQ-036 cfg_blank_en=1, ypbpr_en=1, Sync[2]=0, colour 0xAA -> VD_o={0x00,0x80,0x80} for color_width=8.
REQ-037 cfg_filter 000->100 mid-frame -> filter_pending_o=1; filter_o=11 only after the next Sync[3] falling edge; pending=0 after that.
REQ-038 to_width=4, filter change with no VSYNC -> filter_o updates when the counter reaches 15; assert nVRST_Tx during F_PEND -> filter_o=00, pending=0.
